// File: rtl/cmp_operand_sequencer.sv
// cmp_operand_sequencer
//
// Feeds a power-gated multi-bit comparator from a small operand FIFO. The
// comparator enable is high only while a comparison is in flight. Once the
// settle time has passed, the comparator flags are captured and presented as
// one result per operand pair. Results come out in the order the pairs were
// pushed.
//
// Parameters:
//   WIDTH  - operand width in bits
//   DEPTH  - operand FIFO entries (power of two, >= 2)
//   SETTLE - cycles cmp_enable is held before the sample cycle (>= 1)
//
// Ports:
//   clk, reset             - single clock, synchronous active-high reset
//   in_valid/in_ready      - operand handshake; in_ready is registered (!full)
//   in_a, in_b             - operand pair
//   cmp_enable             - comparator power-gate enable
//   cmp_a, cmp_b           - operands driven to the comparator
//   cmp_lt, cmp_eq, cmp_gt - comparator flags
//   res_valid/res_ready    - result handshake
//   res_lt/eq/gt           - captured flags
//   res_err                - captured flags were not exactly one-hot
//
// Optional build macro CMP_STATS_EN adds stat_clr and four saturating 8-bit
// counters: stat_lt, stat_eq, stat_gt and stat_err.

module cmp_operand_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CMP_STATS_EN
  input  logic             stat_clr,
  output logic [7:0]       stat_lt,
  output logic [7:0]       stat_eq,
  output logic [7:0]       stat_gt,
  output logic [7:0]       stat_err,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_enable,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   count_t;

  typedef enum logic [1:0] {StIdle, StPower, StSample, StResp} state_e;

  state_e          state_q;
  logic [SW-1:0]   settle_q;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  ptr_t             wr_ptr_q, rd_ptr_q;
  count_t           count_q, count_d;

  logic push, pop;
  logic flags_one_hot;

  // in_ready is registered, so a full FIFO refuses the push even when a pop
  // happens in the same cycle.
  assign push = in_valid && in_ready;
  assign pop  = (state_q == StIdle) && (count_q != count_t'(0));

  // Odd parity means one or three flags are set. Excluding the all-set case
  // leaves exactly one.
  assign flags_one_hot = (cmp_lt ^ cmp_eq ^ cmp_gt) & ~(cmp_lt & cmp_eq & cmp_gt);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + count_t'(1);
    end else if (!push && pop) begin
      count_d = count_q - count_t'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      count_q  <= count_d;
      in_ready <= (count_d != count_t'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      cmp_enable <= 1'b0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      res_valid  <= 1'b0;
      res_lt     <= 1'b0;
      res_eq     <= 1'b0;
      res_gt     <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Operands only change on a pop, so the comparator inputs stay quiet
          // while it is gated off.
          if (pop) begin
            cmp_a      <= mem_a[rd_ptr_q];
            cmp_b      <= mem_b[rd_ptr_q];
            cmp_enable <= 1'b1;
            settle_q   <= SW'(SETTLE);
            state_q    <= StPower;
          end
        end
        StPower: begin
          settle_q <= settle_q - SW'(1);
          if (settle_q == SW'(1)) state_q <= StSample;
        end
        StSample: begin
          res_lt     <= cmp_lt;
          res_eq     <= cmp_eq;
          res_gt     <= cmp_gt;
          res_err    <= ~flags_one_hot;
          res_valid  <= 1'b1;
          cmp_enable <= 1'b0;
          state_q    <= StResp;
        end
        StResp: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CMP_STATS_EN
  logic sampling;
  assign sampling = (state_q == StSample);

  // A clear in the same cycle as a sample wins over the increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_lt  <= '0;
      stat_eq  <= '0;
      stat_gt  <= '0;
      stat_err <= '0;
    end else if (sampling) begin
      if (cmp_lt && stat_lt != 8'hFF)          stat_lt  <= stat_lt + 8'd1;
      if (cmp_eq && stat_eq != 8'hFF)          stat_eq  <= stat_eq + 8'd1;
      if (cmp_gt && stat_gt != 8'hFF)          stat_gt  <= stat_gt + 8'd1;
      if (!flags_one_hot && stat_err != 8'hFF) stat_err <= stat_err + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// Testbench for cmp_operand_sequencer. It contains a behavioural comparator
// with fault injection and a reference queue of pushed pairs. Each expected
// result is computed from that queue with plain arithmetic comparisons.
module tb_cmp_operand_sequencer;

  localparam int unsigned W      = 4;
  localparam int unsigned D      = 4;
  localparam int unsigned SETTLE = 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fault;
  } pair_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         cmp_enable;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         res_lt, res_eq, res_gt, res_err;
  logic         fault_on = 1'b0;
  logic         stat_clr = 1'b0;
  logic [7:0]   stat_lt, stat_eq, stat_gt, stat_err;

  int checks = 0;
  int errors = 0;
  pair_t q[$];

  always #5 clk = ~clk;

  // Comparator model: the outputs are gated by the enable. A fault forces
  // both lt and gt high.
  assign cmp_lt = cmp_enable && ((cmp_a < cmp_b) || fault_on);
  assign cmp_gt = cmp_enable && ((cmp_a > cmp_b) || fault_on);
  assign cmp_eq = cmp_enable && (cmp_a == cmp_b) && !fault_on;

  cmp_operand_sequencer #(
    .WIDTH (W),
    .DEPTH (D),
    .SETTLE(SETTLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CMP_STATS_EN
    .stat_clr  (stat_clr),
    .stat_lt   (stat_lt),
    .stat_eq   (stat_eq),
    .stat_gt   (stat_gt),
    .stat_err  (stat_err),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cmp_enable(cmp_enable),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_lt    (cmp_lt),
    .cmp_eq    (cmp_eq),
    .cmp_gt    (cmp_gt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_lt    (res_lt),
    .res_eq    (res_eq),
    .res_gt    (res_gt),
    .res_err   (res_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic f);
    int    n = 0;
    logic  acc = 1'b0;
    pair_t e;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!acc && n < 60) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("push_accept", {31'd0, acc}, 32'd1);
    if (acc) begin
      e.a = a;
      e.b = b;
      e.fault = f;
      q.push_back(e);
    end
  endtask

  // Wait for a result, hold it for a random time, compare it with the oldest
  // queued pair, then accept it.
  task automatic get_result(input string tag);
    int    n = 0;
    int    d;
    int    nflags;
    pair_t e;
    logic  lt, eq, gt, err;
    res_ready = 1'b0;
    while (res_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    if (res_valid !== 1'b1) return;
    if (q.size() == 0) begin
      check({tag, "_stray"}, {31'd0, res_valid}, 32'd0);
      return;
    end
    e = q.pop_front();
    lt = (e.a < e.b) || e.fault;
    gt = (e.a > e.b) || e.fault;
    eq = (e.a == e.b) && !e.fault;
    nflags = int'(lt) + int'(eq) + int'(gt);
    err = (nflags != 1);
    d = $urandom_range(0, 2);
    repeat (d) tick();
    check({tag, "_hold"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_lt"},   {31'd0, res_lt},    {31'd0, lt});
    check({tag, "_eq"},   {31'd0, res_eq},    {31'd0, eq});
    check({tag, "_gt"},   {31'd0, res_gt},    {31'd0, gt});
    check({tag, "_err"},  {31'd0, res_err},   {31'd0, err});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outs", {20'd0, cmp_enable, cmp_a, cmp_b, res_valid, res_lt, res_eq, res_gt,
                       res_err}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_enable", {31'd0, cmp_enable}, 32'd0);
    end

    // Single pair with exact timing
    res_ready = 1'b1;
    in_a = 4'hA;
    in_b = 4'hB;
    in_valid = 1'b1;
    tick();                      // edge k: push
    in_valid = 1'b0;
    check("k0_enable", {31'd0, cmp_enable}, 32'd0);
    tick();                      // k+1: pop
    check("k1_enable", {31'd0, cmp_enable}, 32'd1);
    check("k1_ops", {24'd0, cmp_a, cmp_b}, 32'hAB);
    tick();                      // k+2
    check("k2_enable", {31'd0, cmp_enable}, 32'd1);
    check("k2_valid", {31'd0, res_valid}, 32'd0);
    tick();                      // k+3: result
    check("k3_enable", {31'd0, cmp_enable}, 32'd0);
    check("k3_valid", {31'd0, res_valid}, 32'd1);
    check("k3_flags", {28'd0, res_lt, res_eq, res_gt, res_err}, 32'b1000);
    tick();                      // k+4: consumed
    check("k4_valid", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b0;
    push_pair(4'h8, 4'h8, 1'b0);
    get_result("eq88");

    // Backpressure and ordering
    push_pair(4'd3, 4'd5, 1'b0);
    push_pair(4'd7, 4'd7, 1'b0);
    push_pair(4'd9, 4'd2, 1'b0);
    push_pair(4'd1, 4'd1, 1'b0);
    push_pair(4'd4, 4'd0, 1'b0);
    check("bp_full", {31'd0, in_ready}, 32'd0);
    in_a = 4'd6;
    in_b = 4'd6;
    in_valid = 1'b1;
    tick();
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) get_result("bp");
    repeat (6) tick();
    check("bp_no_extra", {30'd0, res_valid, cmp_enable}, 32'd0);

    // Flag fault, then a clean compare
    fault_on = 1'b1;
    push_pair(4'd2, 4'd9, 1'b1);
    get_result("fault");
    fault_on = 1'b0;
    push_pair(4'd5, 4'd5, 1'b0);
    get_result("post_fault");

    // Randomized bursts checked against the queue model
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) push_pair(W'($urandom), W'($urandom), 1'b0);
      for (int i = 0; i < n; i++) get_result("rand");
    end

    // Reset in POWER with three pairs buffered
    for (int i = 0; i < 5; i++) push_pair(W'(i), W'(4 - i), 1'b0);
    get_result("pre_rst");       // leaves IDLE with 4 buffered
    tick();                      // pop into POWER, 3 buffered
    check("mid_power", {31'd0, cmp_enable}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    check("mid_rst_enable", {31'd0, cmp_enable}, 32'd0);
    check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_stale", {30'd0, cmp_enable, res_valid}, 32'd0);
    end
    push_pair(4'hF, 4'h1, 1'b0);
    get_result("after_rst");

`ifdef CMP_STATS_EN
    for (int i = 0; i < 300; i++) begin
      push_pair(W'(i), W'(i), 1'b0);
      get_result("stat_run");
    end
    check("stat_eq_sat", {24'd0, stat_eq}, 32'hFF);
    check("stat_lt_zero", {24'd0, stat_lt}, 32'd0);
    push_pair(4'd3, 4'd3, 1'b0);
    begin
      int n = 0;
      while (cmp_enable !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    repeat (SETTLE) tick();      // now in the sample cycle
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("clr_at_sample_valid", {31'd0, res_valid}, 32'd1);
    check("stat_eq_clr", {24'd0, stat_eq}, 32'd0);
    get_result("stat_clr_pair");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
